// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared op codes, FSM states and lane helpers for the MEM-stage LSU
package mem_lsu_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} lsu_state_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - little-endian lane pick plus sign/zero extension of load data
module mem_load_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [7:0]        aluop,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata[{addr, 3'b000} +: 8];
    half_v  = addr[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    case (aluop)
      OP_LB:   ld_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      OP_LBU:  ld_data = {{(DATA_W-8){1'b0}}, byte_v};
      OP_LH:   ld_data = {{(DATA_W-16){half_v[15]}}, half_v};
      OP_LHU:  ld_data = {{(DATA_W-16){1'b0}}, half_v};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: req/ack bus transaction with pipeline hold
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic              mem_we,
  input  logic [7:0]        mem_aluop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_sdata,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [REG_AW-1:0] wb_waddr,
  output logic              wb_we,
  output logic              stall_req,
  output logic              mem_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q, ld_data;
  logic [REG_AW-1:0] waddr_q;
  logic              we_q, err_q;
  logic              is_mem, bad_align, start, timed_out;

  assign is_mem    = is_load(mem_aluop) | is_store(mem_aluop);
  assign bad_align = is_mem & misaligned(mem_aluop, mem_addr[1:0]);
  assign start     = (state == ST_IDLE) && is_mem && !bad_align;
  // Ack wins over a timeout landing in the same cycle.
  assign timed_out = (TIMEOUT != 0) && (state == ST_WAIT) && !bus_ack &&
                     (cnt == CNT_W'(TIMEOUT - 1));

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (bus_rdata),
    .addr    (mem_addr[1:0]),
    .aluop   (mem_aluop),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store(mem_aluop);
            bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            bus_sel   <= lane_sel(mem_aluop, mem_addr[1:0]);
            bus_wdata <= store_data(mem_aluop, mem_sdata);
            waddr_q   <= mem_waddr;
            we_q      <= is_load(mem_aluop) & mem_we;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            wdata_q <= ld_data;
          end else if (timed_out) begin
            bus_req <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    mem_err   = err_q;
    wb_wdata  = mem_wdata;
    wb_waddr  = mem_waddr;
    wb_we     = mem_we;
    case (state)
      ST_IDLE: begin
        if (bad_align) begin
          mem_err = 1'b1;
          wb_we   = 1'b0;
        end else if (is_mem) begin
          stall_req = 1'b1;
          wb_we     = 1'b0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_req = 1'b1;
        wb_we     = 1'b0;
        if (bus_ack || timed_out) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        wb_wdata = wdata_q;
        wb_waddr = waddr_q;
        wb_we    = we_q;
        if (!stall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Outputs read as zero for as long as reset is held.
    if (rst) begin
      state_nxt = ST_IDLE;
      stall_req = 1'b0;
      mem_err   = 1'b0;
      wb_wdata  = '0;
      wb_waddr  = '0;
      wb_we     = 1'b0;
    end
  end

endmodule
